// File: rtl/pal_fuse_loader.sv
// ---------------------------------------------------------------------------
// pal_fuse_loader
//
// Writer side of the PAL fuse map. A configuration host streams NUM_BYTES fuse
// bytes followed by one XOR checksum byte over a valid/ready handshake. The
// bytes are collected in a shadow register. The shadow register is copied into
// fuse_map in a single cycle, and only when the checksum matches. This means
// the PAL core never sees a partial or corrupted image.
//
// Fuse layout: byte k, bit b -> fuse bit 8k+b.
// Term t occupies fuse bits [t*2*NUM_INPUTS +: 2*NUM_INPUTS].
// Inside a term, bit 2i is the true literal of input i and bit 2i+1 is its
// complement.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (also clears fuse_map)
//   start      in   begin a load; honoured only when idle
//   abort      in   cancel a load (or a readback) in progress
//   in_data    in   [7:0] fuse / checksum byte
//   in_valid   in   in_data valid
//   in_ready   out  loader accepts a byte (LOAD and CHECK states)
//   fuse_map   out  [FUSE_BITS-1:0] committed fuse map
//   fuse_valid out  fuse_map holds a verified image
//   busy       out  loader not idle
//   done       out  one-cycle pulse when a load finishes (pass or fail)
//   err        out  sticky load failure, cleared by an accepted start
//
// Optional feature, enabled with `define PAL_FUSE_READBACK_EN:
//   rb_req     in   request a readback of the committed map (needs fuse_valid)
//   rb_data    out  [7:0] readback byte: map bytes in load order, then checksum
//   rb_valid   out  rb_data valid
//   rb_ready   in   consumer accepts rb_data
// ---------------------------------------------------------------------------
module pal_fuse_loader #(
    parameter int NUM_INPUTS = 5,
    parameter int NUM_TERMS  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic [7:0]                        in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [2*NUM_INPUTS*NUM_TERMS-1:0] fuse_map,
    output logic                              fuse_valid,
    output logic                              busy,
    output logic                              done,
`ifdef PAL_FUSE_READBACK_EN
    output logic                              err,
    input  logic                              rb_req,
    output logic [7:0]                        rb_data,
    output logic                              rb_valid,
    input  logic                              rb_ready
`else
    output logic                              err
`endif
);
    localparam int FUSE_BITS = 2 * NUM_INPUTS * NUM_TERMS;
    localparam int NUM_BYTES = (FUSE_BITS + 7) / 8;
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
`ifdef PAL_FUSE_READBACK_EN
        ST_CHECK = 2'd2,
        ST_RDBK  = 2'd3
`else
        ST_CHECK = 2'd2
`endif
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_count;
    logic [7:0]             r_csum;
    logic [NUM_BYTES*8-1:0] r_shadow;
    logic [FUSE_BITS-1:0]   r_fuse_map;
    logic                   r_fuse_valid;
    logic                   r_done;
    logic                   r_err;

    // One-cycle event strobes decoded by the FSM.
    logic                   w_start_acc;
    logic                   w_load_xfer;
    logic                   w_check_xfer;
    logic                   w_abort_acc;
    logic [NUM_BYTES-1:0]   w_byte_we;

`ifdef PAL_FUSE_READBACK_EN
    localparam int RB_W = $clog2(NUM_BYTES + 1);
    logic [RB_W-1:0]        r_rb_idx;
    logic                   w_rb_start;
    logic                   w_rb_step;
    logic [NUM_BYTES*8-1:0] w_fuse_pad;
    logic [7:0]             w_fuse_byte [NUM_BYTES];
    logic [7:0]             w_rb_csum;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state and strobes ----------------
    // abort is tested before in_valid so that a byte offered in the
    // abort cycle is dropped rather than stored or checked.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        w_start_acc  = 1'b0;
        w_load_xfer  = 1'b0;
        w_check_xfer = 1'b0;
        w_abort_acc  = 1'b0;
`ifdef PAL_FUSE_READBACK_EN
        w_rb_start   = 1'b0;
        w_rb_step    = 1'b0;
        rb_valid     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_start_acc  = 1'b1;
                    w_state_next = ST_LOAD;
                end
`ifdef PAL_FUSE_READBACK_EN
                else if (rb_req && r_fuse_valid) begin
                    w_rb_start   = 1'b1;
                    w_state_next = ST_RDBK;
                end
`endif
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (abort) begin
                    w_abort_acc  = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (in_valid) begin
                    w_load_xfer = 1'b1;
                    if (r_count == LAST_BYTE) begin
                        w_state_next = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                in_ready = 1'b1;
                if (abort) begin
                    w_abort_acc  = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (in_valid) begin
                    w_check_xfer = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
`ifdef PAL_FUSE_READBACK_EN
            ST_RDBK: begin
                rb_valid = 1'b1;
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (rb_ready) begin
                    w_rb_step = 1'b1;
                    if (r_rb_idx == RB_W'(NUM_BYTES)) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------- Shadow register ----------------
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte_we
        assign w_byte_we[gi] = w_load_xfer && (r_count == CNT_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_shadow <= '0;
        end else begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (w_byte_we[k]) begin
                    r_shadow[k*8 +: 8] <= in_data;
                end
            end
        end
    end

    // ---------------- Counter, checksum, commit, status ----------------
    // Any padding bits in the last byte still enter r_csum. Only the low
    // FUSE_BITS bits of the shadow register are committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= '0;
            r_csum       <= 8'h00;
            r_fuse_map   <= '0;
            r_fuse_valid <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= w_check_xfer;
            if (w_start_acc) begin
                r_count <= '0;
                r_csum  <= 8'h00;
                r_err   <= 1'b0;
            end
            if (w_load_xfer) begin
                r_count <= r_count + CNT_W'(1);
                r_csum  <= r_csum ^ in_data;
            end
            if (w_check_xfer) begin
                if (r_csum == in_data) begin
                    r_fuse_map   <= r_shadow[FUSE_BITS-1:0];
                    r_fuse_valid <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (w_abort_acc) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef PAL_FUSE_READBACK_EN
    // ---------------- Readback ----------------
    // The committed map is zero-padded to whole bytes. The readback checksum
    // is therefore the XOR of exactly the bytes that are streamed out.
    always_comb begin
        w_fuse_pad                = '0;
        w_fuse_pad[FUSE_BITS-1:0] = r_fuse_map;
    end

    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_rb_byte
        assign w_fuse_byte[gi] = w_fuse_pad[gi*8 +: 8];
    end

    always_comb begin
        w_rb_csum = 8'h00;
        for (int k = 0; k < NUM_BYTES; k++) begin
            w_rb_csum = w_rb_csum ^ w_fuse_byte[k];
        end
    end

    always_comb begin
        rb_data = 8'h00;
        if (r_state == ST_RDBK) begin
            rb_data = w_rb_csum;
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (r_rb_idx == RB_W'(k)) begin
                    rb_data = w_fuse_byte[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_rb_start) begin
            r_rb_idx <= '0;
        end else if (w_rb_step) begin
            r_rb_idx <= r_rb_idx + RB_W'(1);
        end
    end
`endif

    assign fuse_map   = r_fuse_map;
    assign fuse_valid = r_fuse_valid;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_pal_fuse_loader.sv
// ---------------------------------------------------------------------------
// tb_pal_fuse_loader
//
// Self-checking bench for pal_fuse_loader (NUM_INPUTS=5, NUM_TERMS=8).
// The bench has four parts:
//   - a table of directed loads with constant expected results;
//   - hand-written sequences for reset, abort and start corner cases;
//   - randomized loads checked against a reference model. The model packs
//     the bytes and XORs them, then applies the commit / err rules;
//   - a readback stream check, present when PAL_FUSE_READBACK_EN is defined.
// ---------------------------------------------------------------------------
module tb_pal_fuse_loader;
    localparam int NB = 10;
    localparam logic [79:0] M1   = 80'h0A090807060504030201;
    localparam logic [79:0] MFF  = {80{1'b1}};
    localparam logic [79:0] M10  = 80'h19181716151413121110;

    typedef logic [7:0] blk_t [NB];

    typedef struct {
        blk_t        bytes;
        logic [7:0]  csum;
        int          gap;
        int          abort_at;   // byte index carrying abort, NB = checksum, -1 = none
        bit          noise;      // toggle start randomly during the load
        logic [79:0] exp_map;
        logic        exp_valid;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start, abort, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, fuse_valid, busy, done, err;
    logic [79:0] fuse_map;
`ifdef PAL_FUSE_READBACK_EN
    logic        rb_req, rb_valid, rb_ready;
    logic [7:0]  rb_data;
`endif

    int n_vec = 0;
    int n_bad = 0;

    logic [79:0] m_map;
    logic        m_valid, m_err;

    vec_t tbl [7];

    always #5 clk = ~clk;

    pal_fuse_loader #(.NUM_INPUTS(5), .NUM_TERMS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fuse_map   (fuse_map),
        .fuse_valid (fuse_valid),
        .busy       (busy),
        .done       (done),
`ifdef PAL_FUSE_READBACK_EN
        .err        (err),
        .rb_req     (rb_req),
        .rb_data    (rb_data),
        .rb_valid   (rb_valid),
        .rb_ready   (rb_ready)
`else
        .err        (err)
`endif
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic check80(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Reference model: the image is the bytes laid end to end.
    // The checksum is the XOR of all bytes.
    function automatic logic [79:0] pack_bytes(input blk_t b);
        logic [79:0] m;
        m = '0;
        for (int k = 0; k < NB; k++) m[8*k +: 8] = b[k];
        return m;
    endfunction

    function automatic logic [7:0] xor_bytes(input blk_t b);
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < NB; k++) x = x ^ b[k];
        return x;
    endfunction

    // Drive one load.
    // Returns right after the cycle that aborted the load or transferred the
    // checksum.
    task automatic do_load(input string tag, input blk_t b, input logic [7:0] cs,
                           input int gap, input int abort_at, input bit noise,
                           output int dones);
        dones = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check1($sformatf("%s.busy_after_start", tag), busy, 1'b1);
        check1($sformatf("%s.err_cleared_by_start", tag), err, 1'b0);
        for (int k = 0; k <= NB; k++) begin
            for (int g = 0; g < gap; g++) begin
                in_data = 8'($urandom);
                tick();
                if (done) dones++;
            end
            check1($sformatf("%s.in_ready[%0d]", tag, k), in_ready, 1'b1);
            in_data  = (k < NB) ? b[k] : cs;
            in_valid = 1'b1;
            abort    = (k == abort_at);
            if (noise) start = 1'($urandom_range(0, 1));
            tick();
            in_valid = 1'b0;
            abort    = 1'b0;
            start    = 1'b0;
            if (k == abort_at) return;
            if (k < NB && done) dones++;
        end
    endtask

    task automatic run_and_check(input string tag, input blk_t b, input logic [7:0] cs,
                                 input int gap, input int abort_at, input bit noise,
                                 input logic [79:0] e_map, input logic e_valid,
                                 input logic e_err);
        int dones;
        do_load(tag, b, cs, gap, abort_at, noise, dones);
        check1($sformatf("%s.done", tag), done, (abort_at < 0));
        checki($sformatf("%s.early_done", tag), dones, 0);
        check1($sformatf("%s.busy_end", tag), busy, 1'b0);
        check1($sformatf("%s.err", tag), err, e_err);
        check80($sformatf("%s.fuse_map", tag), fuse_map, e_map);
        check1($sformatf("%s.fuse_valid", tag), fuse_valid, e_valid);
        tick();
        check1($sformatf("%s.done_clear", tag), done, 1'b0);
        check1($sformatf("%s.in_ready_idle", tag), in_ready, 1'b0);
    endtask

    task automatic set_row(input int i, input blk_t b, input logic [7:0] cs, input int gap,
                           input int abort_at, input bit noise, input logic [79:0] e_map,
                           input logic e_valid, input logic e_err);
        tbl[i].bytes     = b;
        tbl[i].csum      = cs;
        tbl[i].gap       = gap;
        tbl[i].abort_at  = abort_at;
        tbl[i].noise     = noise;
        tbl[i].exp_map   = e_map;
        tbl[i].exp_valid = e_valid;
        tbl[i].exp_err   = e_err;
    endtask

    initial begin
        blk_t seq1, allff, seq10, rb;
        int   dones;

        for (int k = 0; k < NB; k++) begin
            seq1[k]  = 8'(k + 1);
            allff[k] = 8'hFF;
            seq10[k] = 8'(k + 16);
        end
        // 0x01..0x0A XOR to 0x0B; ten 0xFF bytes XOR to 0x00; 0x10..0x19 XOR to 0x01.
        set_row(0, seq1,  8'h0B, 0, -1, 1'b0, M1,  1'b1, 1'b0);
        set_row(1, allff, 8'h01, 0, -1, 1'b0, M1,  1'b1, 1'b1);
        set_row(2, seq1,  8'h0B, 3, -1, 1'b0, M1,  1'b1, 1'b0);
        set_row(3, seq1,  8'h0B, 0,  4, 1'b0, M1,  1'b1, 1'b1);
        set_row(4, allff, 8'h00, 1, -1, 1'b0, MFF, 1'b1, 1'b0);
        set_row(5, seq10, 8'h01, 0, NB, 1'b0, MFF, 1'b1, 1'b1);
        set_row(6, seq10, 8'h01, 2, -1, 1'b1, M10, 1'b1, 1'b0);

        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
`ifdef PAL_FUSE_READBACK_EN
        rb_req = 1'b0; rb_ready = 1'b0;
`endif
        tick();
        tick();
        check80("reset.fuse_map", fuse_map, '0);
        check1("reset.fuse_valid", fuse_valid, 1'b0);
        check1("reset.busy", busy, 1'b0);
        check1("reset.done", done, 1'b0);
        check1("reset.err", err, 1'b0);
        check1("reset.in_ready", in_ready, 1'b0);
        rst = 1'b0;
        tick();

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_and_check($sformatf("row%0d", i), tbl[i].bytes, tbl[i].csum, tbl[i].gap,
                          tbl[i].abort_at, tbl[i].noise, tbl[i].exp_map,
                          tbl[i].exp_valid, tbl[i].exp_err);
        end
        m_map = M10; m_valid = 1'b1; m_err = 1'b0;

        // abort in IDLE is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check1("idle_abort.busy", busy, 1'b0);
        check1("idle_abort.err", err, 1'b0);
        // start and abort together in IDLE: start wins; then abort the load
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check1("start_abort.busy", busy, 1'b1);
        check1("start_abort.err", err, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check1("load_abort.busy", busy, 1'b0);
        check1("load_abort.err", err, 1'b1);
        check1("load_abort.done", done, 1'b0);
        check80("load_abort.fuse_map", fuse_map, m_map);

        // start pulsed mid-load, then rst after the sixth byte
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_data = seq1[k]; in_valid = 1'b1; start = (k == 3);
            tick();
        end
        in_valid = 1'b0; start = 1'b0;
        check1("midload.busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check80("midrst.fuse_map", fuse_map, '0);
        check1("midrst.fuse_valid", fuse_valid, 1'b0);
        check1("midrst.busy", busy, 1'b0);
        check1("midrst.err", err, 1'b0);
        check1("midrst.in_ready", in_ready, 1'b0);
        m_map = '0; m_valid = 1'b0; m_err = 1'b0;
        tick();

        // Randomized loads against the model
        for (int r = 0; r < 40; r++) begin
            blk_t       b;
            logic [7:0] cs;
            int         ab;
            for (int k = 0; k < NB; k++) b[k] = 8'($urandom);
            cs = ($urandom_range(0, 1) == 1) ? xor_bytes(b) : 8'($urandom);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB)) : -1;
            if (ab >= 0) begin
                m_err = 1'b1;
            end else if (cs == xor_bytes(b)) begin
                m_map = pack_bytes(b); m_valid = 1'b1; m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
            run_and_check($sformatf("rnd%0d", r), b, cs, int'($urandom_range(0, 2)), ab,
                          1'($urandom_range(0, 1)), m_map, m_valid, m_err);
        end

`ifdef PAL_FUSE_READBACK_EN
        // Readback of a known image with a toggling consumer
        run_and_check("rb_load", seq1, 8'h0B, 0, -1, 1'b0, M1, 1'b1, 1'b0);
        begin
            logic [7:0] got_seq [NB+1];
            int got, cyc;
            logic [7:0] exp_b;
            got = 0; cyc = 0;
            rb_req = 1'b1;
            tick();
            rb_req = 1'b0;
            check1("rb.busy_start", busy, 1'b1);
            while (got < NB + 1 && cyc < 200) begin
                rb_ready = 1'($urandom_range(0, 1));
                if (busy !== 1'b1) begin
                    check1("rb.busy_hold", busy, 1'b1);
                end
                if (rb_valid && rb_ready) begin
                    got_seq[got] = rb_data;
                    got++;
                end
                tick();
                cyc++;
            end
            rb_ready = 1'b0;
            checki("rb.count", got, NB + 1);
            for (int k = 0; k <= NB && k < got; k++) begin
                exp_b = (k < NB) ? 8'(k + 1) : 8'h0B;
                check80($sformatf("rb.byte%0d", k), {72'h0, got_seq[k]}, {72'h0, exp_b});
            end
            check1("rb.busy_end", busy, 1'b0);
            check1("rb.valid_end", rb_valid, 1'b0);
            check1("rb.no_done", done, 1'b0);
        end
`endif

        dones = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
